// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues req/ack word fetches and buffers them in a prefetch FIFO; zero-wait data is valid one cycle after req.
// Backpressure: stall holds the head entry, requests pause while the FIFO is full, and a taken branch flushes the FIFO and drains any in-flight fetch.

module ifu_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_vld_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic         head_vld_o,
  output logic [W-1:0] head_dat_o,
  output logic         full_nxt_o
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  dat_q [DEPTH];
  logic [W-1:0]  dat_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;

  // Head lives in slot 0 and vacated slots are zeroed, so an empty FIFO reads as 0.
  always_comb begin
    dat_d = dat_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) dat_d[i] = '0;
      cnt_d = '0;
    end else begin
      if (pop_i && cnt_q != '0) begin
        for (int i = 0; i < DEPTH - 1; i++) dat_d[i] = dat_q[i+1];
        dat_d[DEPTH-1] = '0;
        cnt_d = cnt_q - CW'(1);
      end
      if (push_vld_i && cnt_d != CW'(DEPTH)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cnt_d == CW'(i)) dat_d[i] = push_dat_i;
        end
        cnt_d = cnt_d + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_vld_o = (cnt_q != '0);
  assign head_dat_o = dat_q[0];
  assign full_nxt_o = (cnt_d == CW'(DEPTH));
endmodule

module instr_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       Instr,
  output logic [ADDR_W-1:0] InstrPC,
  output logic [ADDR_W-1:0] PCPlus8,
  output logic              instr_valid
);
  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} state_e;
  localparam int EW = ADDR_W + 32;

  state_e            state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic              req_q;
  logic              head_vld;
  logic              full_nxt;
  logic [EW-1:0]     head_dat;
  logic              ack;
  logic              consume;
  logic              redirect;
  logic              push;

  // An ack only counts against a request we are actually driving.
  assign ack      = imem_ack & req_q;
  assign consume  = head_vld & ~stall;
  assign redirect = consume & PCSrc;
  assign push     = ack & (state_q == S_REQ) & ~redirect;

  ifu_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (reset),
    .flush_i    (redirect),
    .push_vld_i (push),
    .push_dat_i ({fetch_pc_q, imem_rdata}),
    .pop_i      (consume),
    .head_vld_o (head_vld),
    .head_dat_o (head_dat),
    .full_nxt_o (full_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (redirect) begin
            fetch_pc_q <= BranchTarget;
            if (ack || !req_q) begin
              req_q  <= 1'b1;
              addr_q <= BranchTarget;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (ack) begin
            fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
            if (full_nxt) begin
              state_q <= S_HOLD;
              req_q   <= 1'b0;
            end else begin
              addr_q <= fetch_pc_q + ADDR_W'(4);
            end
          end else begin
            req_q  <= 1'b1;
            addr_q <= fetch_pc_q;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            fetch_pc_q <= BranchTarget;
            state_q    <= S_REQ;
            req_q      <= 1'b1;
            addr_q     <= BranchTarget;
          end else if (consume) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q;
          end
        end
        S_DRAIN: begin
          // Stale word is dropped; fetch_pc already holds the branch target.
          if (ack) begin
            state_q <= S_REQ;
            addr_q  <= fetch_pc_q;
          end
        end
        default: begin
          state_q <= S_REQ;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = head_vld;
  assign {InstrPC, Instr} = head_dat;
  assign PCPlus8     = head_vld ? (InstrPC + ADDR_W'(8)) : '0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized phase, checked against a stream/fetch-order reference model.
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk, reset, PCSrc, stall, imem_req, imem_ack, instr_valid;
  logic [31:0] BranchTarget, imem_addr, imem_rdata, Instr, InstrPC, PCPlus8;

  int          n_tests = 0;
  int          n_fail = 0;
  logic        in_req = 1'b0;
  logic        stale = 1'b0;
  logic        prev_redirect = 1'b0;
  logic        spurious = 1'b0;
  int          wait_cnt = 0;
  int          lat = 0;
  int          lat_mode = 0;
  int          n_consumed = 0;
  logic [31:0] cur_addr = '0;
  logic [31:0] next_fetch = RST_PC;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] key = '0;

  instr_fetch_unit #(
    .ADDR_W     (32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .Instr        (Instr),
    .InstrPC      (InstrPC),
    .PCPlus8      (PCPlus8),
    .instr_valid  (instr_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder plus reference model; called at a falling edge, returns at the next falling edge.
  task automatic tick();
    logic ack, consume, redirect;
    ack = 1'b0;
    if (in_req) begin
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", imem_addr, cur_addr);
    end else if (imem_req) begin
      in_req   = 1'b1;
      cur_addr = imem_addr;
      wait_cnt = 0;
      lat      = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
      chk("req_addr", imem_addr, next_fetch);
    end
    if (in_req) begin
      ack = (wait_cnt >= lat);
      wait_cnt++;
      imem_ack   = ack;
      imem_rdata = ack ? (cur_addr ^ key) : $urandom();
    end else begin
      imem_ack   = spurious;
      imem_rdata = $urandom();
    end

    consume  = instr_valid && !stall;
    redirect = consume && PCSrc;
    if (prev_redirect) chk("bubble", 32'(instr_valid), 32'd0);
    if (instr_valid) begin
      chk("InstrPC", InstrPC, exp_pc);
      chk("Instr", Instr, exp_pc ^ key);
      chk("PCPlus8", PCPlus8, exp_pc + 32'd8);
    end else begin
      chk("Instr_zero", Instr, 32'd0);
    end

    if (consume) begin
      n_consumed++;
      exp_pc = redirect ? BranchTarget : exp_pc + 32'd4;
    end
    prev_redirect = redirect;
    if (redirect) begin
      next_fetch = BranchTarget;
      stale      = in_req && !ack;
    end else if (in_req && ack) begin
      if (stale) stale = 1'b0;
      else next_fetch = next_fetch + 32'd4;
    end
    if (ack) in_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_req_async", 32'(imem_req), 32'd0);
    chk("rst_vld_async", 32'(instr_valid), 32'd0);
    imem_ack = 1'b0;
    stall    = 1'b0;
    PCSrc    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_Instr", Instr, 32'd0);
    chk("rst_InstrPC", InstrPC, 32'd0);
    chk("rst_PCPlus8", PCPlus8, 32'd0);
    in_req        = 1'b0;
    stale         = 1'b0;
    prev_redirect = 1'b0;
    next_fetch    = RST_PC;
    exp_pc        = RST_PC;
    reset         = 1'b1;
  endtask

  task automatic run_until_valid(input int max, input string tag);
    int n = 0;
    while (!instr_valid && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    reset = 1'b0; PCSrc = 1'b0; stall = 1'b0; BranchTarget = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    @(negedge clk);

    // 1: reset release, zero-wait memory returning addr-as-data
    lat_mode = 0; key = '0;
    do_reset();
    chk("t1_req_rst", 32'(imem_req), 32'd0);
    tick();
    chk("t1_req_first", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, RST_PC);
    chk("t1_vld0", 32'(instr_valid), 32'd0);
    tick();
    chk("t1_instr0", Instr, 32'h0);
    chk("t1_p8_0", PCPlus8, 32'h8);
    tick();
    chk("t1_instr4", Instr, 32'h4);
    chk("t1_p8_4", PCPlus8, 32'hC);
    tick();
    chk("t1_instr8", Instr, 32'h8);
    chk("t1_p8_8", PCPlus8, 32'h10);
    chk("t1_addr12", imem_addr, 32'hC);

    // 2: stall for four cycles
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_stall_hold", Instr, 32'h8);
      tick();
    end
    chk("t2_hold_req", 32'(imem_req), 32'd0);
    chk("t2_hold_instr", Instr, 32'h8);
    stall = 1'b0;
    repeat (8) tick();

    // 3: redirect from HOLD (nothing outstanding)
    do_reset();
    repeat (4) tick();
    stall = 1'b1;
    repeat (2) tick();
    chk("t3_pc8", InstrPC, 32'h8);
    chk("t3_no_req", 32'(imem_req), 32'd0);
    stall = 1'b0; PCSrc = 1'b1; BranchTarget = 32'h100;
    tick();
    PCSrc = 1'b0;
    run_until_valid(10, "t3_vld");
    chk("t3_target", InstrPC, 32'h100);

    // 4: redirect while a slow request is outstanding
    do_reset();
    lat_mode = 3;
    run_until_valid(20, "t4_vld");
    chk("t4_pc0", InstrPC, 32'h0);
    chk("t4_outstanding", 32'(imem_req), 32'd1);
    PCSrc = 1'b1; BranchTarget = 32'h100;
    tick();
    PCSrc = 1'b0;
    chk("t4_drain_req", 32'(imem_req), 32'd1);
    chk("t4_drain_addr", imem_addr, 32'h4);
    run_until_valid(20, "t4_vld2");
    chk("t4_target", InstrPC, 32'h100);

    // 5: throughput with 2-cycle and zero-wait memory
    lat_mode = 1;
    repeat (10) tick();
    n_consumed = 0;
    repeat (20) tick();
    chk("t5_tput_lat2", 32'(n_consumed), 32'd10);
    lat_mode = 0;
    repeat (6) tick();
    n_consumed = 0;
    repeat (20) tick();
    chk("t5_tput_lat1", 32'(n_consumed), 32'd20);

    // address wrap past the top of memory
    PCSrc = 1'b1; BranchTarget = 32'hFFFF_FFF8;
    tick();
    PCSrc = 1'b0;
    run_until_valid(10, "wrap_vld");
    chk("wrap_pc_f8", InstrPC, 32'hFFFF_FFF8);
    tick();
    chk("wrap_p8", PCPlus8, 32'h4);
    tick();
    chk("wrap_pc0", InstrPC, 32'h0);

    // 6: reset in the middle of a wait, then a stray ack
    lat_mode = 3;
    for (int n = 0; n < 20 && !(in_req && wait_cnt == 2); n++) tick();
    chk("t6_midwait", 32'(in_req), 32'd1);
    do_reset();
    spurious = 1'b1;
    run_until_valid(20, "t6_vld");
    chk("t6_restart_pc", InstrPC, RST_PC);
    chk("t6_restart_instr", Instr, RST_PC ^ key);

    // randomized phase
    do_reset();
    key = $urandom();
    lat_mode = -1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) do_reset();
      stall = ($urandom_range(9, 0) < 3);
      PCSrc = ($urandom_range(9, 0) == 0);
      BranchTarget = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hC))
                                                 : ($urandom() & 32'hFFFF_FFFC);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction decoder/controller.
- Owns the program counter and issues word requests to instruction memory over a req/ack handshake with variable latency.
- Buffers returned words in a small prefetch FIFO and presents one instruction per cycle (Instr, InstrPC, PCPlus8) with a valid flag.
- Redirects and flushes when the downstream stage takes a branch.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries (power of two, >=2).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- PCSrc  input  1  redirect request from controller; valid only while instr_valid=1.
- BranchTarget  input  ADDR_W  redirect address, word-aligned.
- stall  input  1  downstream not ready; head entry is not consumed.
- imem_req  output  1  instruction memory request.
- imem_addr  output  ADDR_W  request address.
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  32  instruction word, valid with imem_ack.
- Instr  output  32  head instruction.
- InstrPC  output  ADDR_W  address of Instr.
- PCPlus8  output  ADDR_W  InstrPC+8 (ARM visible PC).
- instr_valid  output  1  head entry is valid.

Behaviour:
- Reset (reset=0, async):
  - fetch_pc=RESET_PC, FIFO empty, state=REQ, imem_req=0.
  - instr_valid=0, Instr=0, InstrPC=0, PCPlus8=0.
  - imem_req asserts in the first cycle after reset deasserts.
- Consume = instr_valid & ~stall. The FIFO pops on consume.
- Redirect = consume & PCSrc. PCSrc with instr_valid=0 or stall=1 is ignored.
- FSM states REQ, HOLD, DRAIN:
  - REQ:
    - imem_req=1, imem_addr=fetch_pc, both held stable until imem_ack.
    - On ack without redirect: push {fetch_pc, imem_rdata}, fetch_pc+=4.
    - After the push, go to HOLD if the FIFO is full; otherwise stay in REQ.
  - HOLD:
    - imem_req=0.
    - Return to REQ in the cycle after a pop makes room.
  - DRAIN:
    - Outstanding request completing after a redirect. imem_req stays 1 at the old address until ack.
    - The acked data is discarded. Then go to REQ at the redirect target.
- Redirect handling:
  - Flush the FIFO, including any same-cycle push. fetch_pc<=BranchTarget.
  - If a request is outstanding and not acked this cycle: go to DRAIN.
  - If the request is acked this cycle, or none is outstanding: go to REQ.
  - The first instruction from the target is never earlier than the cycle after the redirect.
- Push and pop in the same cycle are legal. Count is unchanged. A push into a full FIFO cannot occur because no request is issued while full.
- Latency: with zero-wait memory (ack in the same cycle as req), data returns one cycle after req. Sustained throughput is 1 instr/cycle when stall=0.
- Outputs are registered from the FIFO head.
  - When instr_valid=0: Instr=0. Downstream must gate its writes with instr_valid.
  - PCPlus8 = InstrPC+8, wrapping mod 2^ADDR_W.
- fetch_pc wraps from 32'hFFFF_FFFC to 0 without error.
- imem_rdata is ignored unless imem_ack=1. imem_ack without an outstanding req is ignored.
- Reset mid-request: the request is abandoned and imem_req drops immediately. A late ack after reset is ignored unless a new req is outstanding.

Test Plan:
1. Reset release with zero-wait memory returning addr-as-data:
   - Addresses 0,4,8,12 are requested on consecutive cycles.
   - instr_valid rises 1 cycle after the first req.
   - Instr=0,4,8; PCPlus8=8,12,16.
2. stall=1 for 4 cycles:
   - The FIFO fills to 2 and imem_req drops (HOLD).
   - Instr holds at its value.
   - On stall=0, the sequence resumes with no lost or duplicated words.
3. Redirect with no outstanding request:
   - PCSrc=1 and BranchTarget=0x100 while consuming InstrPC=0x8.
   - The next valid InstrPC=0x100, with a bubble of at least 1 cycle.
   - Prefetched 0xC is never presented.
4. Redirect while a request is outstanding (ack delayed 3 cycles):
   - imem_addr holds the old address until ack.
   - Returned data is discarded; the next request is 0x100.
5. Memory with 2-cycle latency:
   - imem_req and imem_addr are stable across wait cycles.
   - Throughput is 1 instr per 2 cycles with correct PCs.
6. Assert reset mid-wait:
   - imem_req=0 and instr_valid=0 asynchronously.
   - After release, fetching restarts at RESET_PC.
